// File: rtl/packet_bit_timer.sv
// packet_bit_timer: times one serial packet of BITS_PER_PKT bits, each
// CLKS_PER_BIT clocks long. It emits a strobe at the end of every bit period
// and a one-cycle done pulse after the last bit. Holding start high gives
// back-to-back packets with no idle gap. All outputs are decoded from
// registered state only.
module packet_bit_timer #(
    parameter int CLKS_PER_BIT = 10,  // legal range 2..31
    parameter int BITS_PER_PKT = 9    // legal range 1..31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic [4:0] clk_cnt,
    output logic [4:0] bit_idx,
    output logic       shift_strobe,
    output logic       packet_done,
    output logic       busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [4:0] LAST_CNT = 5'(CLKS_PER_BIT);
    localparam logic [4:0] LAST_BIT = 5'(BITS_PER_PKT - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [4:0] cnt_nxt;
    logic [4:0] idx_nxt;

    // Moore decodes of the registered state; start and abort never reach an output.
    assign shift_strobe = (state == RUN) && (clk_cnt == LAST_CNT);
    assign packet_done  = (state == DONE);
    assign busy         = (state != IDLE);

    // Next-state and counter logic; abort outranks start everywhere.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latch.
        state_nxt = IDLE;
        cnt_nxt   = 5'd0;
        idx_nxt   = 5'd0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = RUN;
                    cnt_nxt   = 5'd1;
                end
            end
            RUN: begin
                if (!abort) begin
                    if (!shift_strobe) begin
                        state_nxt = RUN;
                        cnt_nxt   = clk_cnt + 5'd1;
                        idx_nxt   = bit_idx;
                    end else if (bit_idx != LAST_BIT) begin
                        state_nxt = RUN;
                        cnt_nxt   = 5'd1;
                        idx_nxt   = bit_idx + 5'd1;
                    end else begin
                        // Last bit finished: counters already cleared by the defaults.
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                // A held start chains straight into the next packet.
                if (start && !abort) begin
                    state_nxt = RUN;
                    cnt_nxt   = 5'd1;
                end
            end
            default: begin
                // Unreachable encoding recovers to IDLE with cleared counters.
                state_nxt = IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset taking top priority.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state   <= IDLE;
            clk_cnt <= 5'd0;
            bit_idx <= 5'd0;
        end else begin
            state   <= state_nxt;
            clk_cnt <= cnt_nxt;
            bit_idx <= idx_nxt;
        end
    end

endmodule

// File: tb/tb_packet_bit_timer.sv
// Scoreboard bench for packet_bit_timer. Three instances cover the default
// parameters (10/9) and both corners (2/1 and 31/31). Stimulus pushes the
// expected strobe/done events and state snapshots into queues; a monitor on
// the falling edge pops and compares whenever an instance emits an event or
// a snapshot cycle arrives. Cycle n of a packet is cyc == base + n, where
// base is the cycle during which start was driven.
module tb_packet_bit_timer;

    localparam int NDUT = 3;

    typedef struct {
        int cyc;
        int dut;
        bit done;
        int idx;
    } ev_t;

    typedef struct {
        int cyc;
        int dut;
        bit busy;
        int cnt;
        int idx;
    } probe_t;

    ev_t    ev_q[$];
    probe_t pr_q[$];
    probe_t p_cur;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int base;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NDUT-1:0] start = '0;
    logic [NDUT-1:0] abort = '0;
    logic [4:0]      cnt_a  [NDUT];
    logic [4:0]      bidx_a [NDUT];
    logic [NDUT-1:0] strobe_v;
    logic [NDUT-1:0] done_v;
    logic [NDUT-1:0] busy_v;

    packet_bit_timer #(.CLKS_PER_BIT(10), .BITS_PER_PKT(9)) dut_def (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
        .clk_cnt(cnt_a[0]), .bit_idx(bidx_a[0]),
        .shift_strobe(strobe_v[0]), .packet_done(done_v[0]), .busy(busy_v[0])
    );

    packet_bit_timer #(.CLKS_PER_BIT(2), .BITS_PER_PKT(1)) dut_min (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
        .clk_cnt(cnt_a[1]), .bit_idx(bidx_a[1]),
        .shift_strobe(strobe_v[1]), .packet_done(done_v[1]), .busy(busy_v[1])
    );

    packet_bit_timer #(.CLKS_PER_BIT(31), .BITS_PER_PKT(31)) dut_max (
        .clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]),
        .clk_cnt(cnt_a[2]), .bit_idx(bidx_a[2]),
        .shift_strobe(strobe_v[2]), .packet_done(done_v[2]), .busy(busy_v[2])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Compare one observed strobe/done against the head of the event queue.
    task automatic check_event(input int d, input bit is_done);
        ev_t e;
        n_cmp++;
        if (ev_q.size() == 0) begin
            n_bad++;
            $display("FAIL event: dut%0d cyc=%0d got done=%0d idx=%0d, expected no event",
                     d, cyc, is_done, bidx_a[d]);
            return;
        end
        e = ev_q.pop_front();
        if (e.dut != d || e.cyc != cyc || e.done != is_done || bidx_a[d] !== 5'(e.idx)) begin
            n_bad++;
            $display("FAIL event: got dut%0d cyc=%0d done=%0d idx=%0d, expected dut%0d cyc=%0d done=%0d idx=%0d",
                     d, cyc, is_done, bidx_a[d], e.dut, e.cyc, e.done, e.idx);
        end
    endtask

    // Monitor: events as they appear, then any snapshot due this cycle.
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (strobe_v[d] !== 1'b0) check_event(d, 1'b0);
            if (done_v[d]   !== 1'b0) check_event(d, 1'b1);
        end
        while (pr_q.size() > 0 && pr_q[0].cyc <= cyc) begin
            p_cur = pr_q.pop_front();
            n_cmp++;
            if (p_cur.cyc != cyc || busy_v[p_cur.dut] !== p_cur.busy ||
                cnt_a[p_cur.dut] !== 5'(p_cur.cnt) || bidx_a[p_cur.dut] !== 5'(p_cur.idx)) begin
                n_bad++;
                $display("FAIL state: dut%0d cyc=%0d got busy=%0d cnt=%0d idx=%0d, expected cyc=%0d busy=%0d cnt=%0d idx=%0d",
                         p_cur.dut, cyc, busy_v[p_cur.dut], cnt_a[p_cur.dut], bidx_a[p_cur.dut],
                         p_cur.cyc, p_cur.busy, p_cur.cnt, p_cur.idx);
            end
        end
    end

    task automatic push_packet(input int d, input int b, input int cpb, input int bpp,
                               input int kmax, input bit with_done);
        for (int k = 1; k <= kmax; k++) ev_q.push_back('{b + k * cpb, d, 1'b0, k - 1});
        if (with_done) ev_q.push_back('{b + bpp * cpb + 1, d, 1'b1, 0});
    endtask

    task automatic push_probe(input int c, input int d, input bit bsy, input int cnt, input int idx);
        pr_q.push_back('{c, d, bsy, cnt, idx});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset holds everything idle, even with start asserted.
        rst = 1'b1;
        repeat (3) tick();
        start[0] = 1'b1;
        for (int d = 0; d < NDUT; d++) push_probe(cyc + 1, d, 1'b0, 0, 0);
        tick();
        start[0] = 1'b0;
        rst = 1'b0;
        tick();

        // Basic default packet.
        base = cyc;
        start[0] = 1'b1;
        push_packet(0, base, 10, 9, 9, 1'b1);
        push_probe(base + 1,  0, 1'b1, 1, 0);
        push_probe(base + 91, 0, 1'b1, 0, 0);
        push_probe(base + 92, 0, 1'b0, 0, 0);
        tick();
        start[0] = 1'b0;
        wait_cyc(base + 95);

        // Start re-pulsed mid-packet is ignored.
        base = cyc;
        start[0] = 1'b1;
        push_packet(0, base, 10, 9, 9, 1'b1);
        push_probe(base + 1,  0, 1'b1, 1, 0);
        push_probe(base + 34, 0, 1'b1, 4, 3);
        push_probe(base + 92, 0, 1'b0, 0, 0);
        tick();
        start[0] = 1'b0;
        wait_cyc(base + 33);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        wait_cyc(base + 95);

        // start and abort together in IDLE stay idle.
        start[0] = 1'b1;
        abort[0] = 1'b1;
        push_probe(cyc + 1, 0, 1'b0, 0, 0);
        tick();
        start[0] = 1'b0;
        abort[0] = 1'b0;
        tick();

        // Abort during cycle 45: idle at 46, no strobe at 50, no done.
        base = cyc;
        start[0] = 1'b1;
        push_packet(0, base, 10, 9, 4, 1'b0);
        push_probe(base + 45, 0, 1'b1, 5, 4);
        push_probe(base + 46, 0, 1'b0, 0, 0);
        tick();
        start[0] = 1'b0;
        wait_cyc(base + 45);
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        wait_cyc(base + 100);

        // Back-to-back packets with start held through DONE.
        base = cyc;
        start[0] = 1'b1;
        push_packet(0, base, 10, 9, 9, 1'b1);
        push_packet(0, base + 91, 10, 9, 9, 1'b1);
        push_probe(base + 91,  0, 1'b1, 0, 0);
        push_probe(base + 92,  0, 1'b1, 1, 0);
        push_probe(base + 101, 0, 1'b1, 10, 0);
        push_probe(base + 182, 0, 1'b1, 0, 0);
        push_probe(base + 183, 0, 1'b0, 0, 0);
        wait_cyc(base + 92);
        start[0] = 1'b0;
        wait_cyc(base + 186);

        // Reset sampled at edge 90: strobe at 90 is seen, nothing after it.
        base = cyc;
        start[0] = 1'b1;
        push_packet(0, base, 10, 9, 9, 1'b0);
        push_probe(base + 91, 0, 1'b0, 0, 0);
        tick();
        start[0] = 1'b0;
        wait_cyc(base + 90);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // First start after reset gives a complete, correctly timed packet.
        base = cyc;
        start[0] = 1'b1;
        push_packet(0, base, 10, 9, 9, 1'b1);
        push_probe(base + 1,  0, 1'b1, 1, 0);
        push_probe(base + 92, 0, 1'b0, 0, 0);
        tick();
        start[0] = 1'b0;
        wait_cyc(base + 95);

        // Minimum corner: CLKS_PER_BIT=2, BITS_PER_PKT=1.
        base = cyc;
        start[1] = 1'b1;
        push_packet(1, base, 2, 1, 1, 1'b1);
        push_probe(base + 1, 1, 1'b1, 1, 0);
        push_probe(base + 2, 1, 1'b1, 2, 0);
        push_probe(base + 3, 1, 1'b1, 0, 0);
        push_probe(base + 4, 1, 1'b0, 0, 0);
        tick();
        start[1] = 1'b0;
        wait_cyc(base + 6);

        // Maximum corner: CLKS_PER_BIT=31, BITS_PER_PKT=31.
        base = cyc;
        start[2] = 1'b1;
        push_packet(2, base, 31, 31, 31, 1'b1);
        push_probe(base + 31,  2, 1'b1, 31, 0);
        push_probe(base + 32,  2, 1'b1, 1, 1);
        push_probe(base + 961, 2, 1'b1, 31, 30);
        push_probe(base + 962, 2, 1'b1, 0, 0);
        push_probe(base + 963, 2, 1'b0, 0, 0);
        tick();
        start[2] = 1'b0;
        wait_cyc(base + 966);

        // Every expectation must have been consumed.
        n_cmp++;
        if (ev_q.size() != 0 || pr_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d events and %0d snapshots pending, expected 0 and 0",
                     ev_q.size(), pr_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/packet_bit_timer.md
PACKET_BIT_TIMER -- requirements
Module: packet_bit_timer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10: clock cycles per serial bit, legal range 2..31.
REQ-002 Parameter BITS_PER_PKT, default 9: bits per packet, legal range 1..31.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port start  input  1  request to begin timing one packet.
REQ-006 Port abort  input  1  cancel the packet in progress.
REQ-007 Port clk_cnt  output  5  clock count within the current bit, 1..CLKS_PER_BIT while running.
REQ-008 Port bit_idx  output  5  index of the current bit, 0..BITS_PER_PKT-1 while running.
REQ-009 Port shift_strobe  output  1  one-cycle pulse at the end of each bit period.
REQ-010 Port packet_done  output  1  one-cycle pulse after the last bit completes.
REQ-011 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE SHALL hold clk_cnt=0 and bit_idx=0.
REQ-014 IDLE with start=1 and abort=0 SHALL transition to RUN, with clk_cnt=1 and bit_idx=0 on the next cycle.
REQ-015 RUN with clk_cnt<CLKS_PER_BIT SHALL increment clk_cnt by 1 each cycle.
REQ-016 RUN with clk_cnt==CLKS_PER_BIT SHALL wrap clk_cnt to 1.
REQ-017 shift_strobe SHALL be a Moore decode: 1 iff state==RUN and clk_cnt==CLKS_PER_BIT.
REQ-018 On a strobe cycle with bit_idx<BITS_PER_PKT-1, bit_idx SHALL increment by 1 next cycle.
REQ-019 On a strobe cycle with bit_idx==BITS_PER_PKT-1, the next state SHALL be DONE, with clk_cnt=0 and bit_idx=0.
REQ-020 packet_done SHALL be 1 iff state==DONE, and DONE SHALL last exactly one cycle.
REQ-021 DONE with start=1 and abort=0 SHALL go directly to RUN (clk_cnt=1, bit_idx=0), giving back-to-back packets with no idle gap.
REQ-022 DONE with start=0 SHALL return to IDLE.
REQ-023 start while in RUN SHALL be ignored, with no restart or counter disturbance.
REQ-024 abort=1 in RUN or DONE SHALL force IDLE next cycle with counters cleared and no further shift_strobe or packet_done.
REQ-025 abort SHALL take priority over start in every state; start=1 and abort=1 together in IDLE SHALL leave the block in IDLE.
REQ-026 Packet timing with start sampled at edge 0: strobes at cycles k*CLKS_PER_BIT for k=1..BITS_PER_PKT; packet_done at cycle BITS_PER_PKT*CLKS_PER_BIT+1.
REQ-027 All counters SHALL be 5-bit unsigned, and no value outside the ranges in REQ-007/REQ-008 SHALL ever appear on the outputs.
REQ-028 Outputs SHALL be glitch-free decodes of registered state only, with no combinational path from start or abort to any output.

Reset
REQ-029 rst=1 at a rising edge SHALL force IDLE, clk_cnt=0, bit_idx=0, shift_strobe=0, packet_done=0 and busy=0 on the following cycle, from any state.
REQ-030 rst SHALL take priority over start and abort.
REQ-031 rst asserted mid-packet SHALL suppress any pending strobe or packet_done.
REQ-032 The first start accepted after rst deasserts SHALL produce a complete, correctly timed packet.

Verification
REQ-033 Defaults (10/9): start pulse at cycle 0 -> shift_strobe at cycles 10,20,...,90 with bit_idx 0..8 on those cycles; packet_done at cycle 91; busy high cycles 1..91; IDLE at 92.
REQ-034 Back-to-back: start held high through DONE (cycle 91) -> RUN at cycle 92 with clk_cnt=1; second packet's first strobe at cycle 101, second packet_done at cycle 182.
REQ-035 Abort: abort at cycle 45 -> IDLE at 46, counters 0, no strobe at cycle 50, no packet_done.
REQ-036 Ignored start and priority: start re-pulsed at cycle 33 -> timing identical to REQ-033; start=abort=1 in IDLE -> busy stays 0.
REQ-037 Reset mid-run: rst at cycle 90 -> no strobe or packet_done after it, all outputs 0 at cycle 91; a new start then reproduces REQ-033 timing.
REQ-038 Boundary parameters: CLKS_PER_BIT=2, BITS_PER_PKT=1 -> single strobe at cycle 2, packet_done at cycle 3; CLKS_PER_BIT=31, BITS_PER_PKT=31 -> clk_cnt reaches 31 and wraps to 1, bit_idx reaches 30, packet_done at cycle 962.
